fu_csr_q: RTL

- Parametrised CSR functional unit. Next generation of the single-entry CSR FU.
- Holds up to DEPTH non-speculative CSR writes in an in-order queue until their instruction retires.
- Forwards the youngest queued value to younger CSR reads, so back-to-back CSR ops do not serialise.
- Sits between issue and writeback. Drives the architectural CSR file read and write ports, and obeys the squash broadcast.

---
 rtl/fu_csr_q.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fu_csr_q.sv
// CSR functional unit with an in-order queue of pending CSR writes that commit at retire.
// Define FU_CSR_FWD_EN to forward queued values to younger CSR ops; otherwise CSR ops fully serialise.
module fu_csr_q #(
    parameter int XLEN  = 64,
    parameter int ID_W  = 6,
    parameter int PRD_W = 7,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ID_W-1:0]   in_id,
    input  logic [PRD_W-1:0]  in_prd,
    input  logic [11:0]       in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    output logic [PRD_W-1:0]  out_prd,
    output logic [XLEN-1:0]   out_rdval,
    output logic              out_exc,
    output logic [11:0]       csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic [11:0]       csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_wvalid,
    input  logic              retire_valid,
    input  logic [ID_W-1:0]   retire_id,
    input  logic              squash_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic [ID_W-1:0]  qid_q   [DEPTH];
    logic [11:0]      qaddr_q [DEPTH];
    logic [XLEN-1:0]  qdata_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [PRD_W-1:0] out_prd_q, out_prd_d;
    logic [XLEN-1:0]  out_rdval_q, out_rdval_d;
    logic             out_exc_q, out_exc_d;

    logic             exc, accept, enq, pop;
    logic [XLEN-1:0]  old_val, new_val;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef FU_CSR_FWD_EN
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_W = (PTR_W + 1)'(DEPTH);
    logic [PTR_W:0] slot;

    assign in_ready = (count_q < DEPTH_C);

    // Walk oldest to youngest so the last match is the youngest queued value.
    always_comb begin
        old_val = csr_rdata;
        slot    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = {1'b0, head_q} + (PTR_W + 1)'(i);
            if (slot >= DEPTH_W) slot = slot - DEPTH_W;
            if ((CNT_W'(i) < count_q) && (qaddr_q[slot[PTR_W-1:0]] == in_addr))
                old_val = qdata_q[slot[PTR_W-1:0]];
        end
    end
`else
    assign in_ready = (count_q == '0);

    always_comb begin
        old_val = csr_rdata;
    end
`endif

    assign csr_raddr = in_addr;

    always_comb begin
        exc = (in_addr[9:8] != 2'b11) || ((in_op != OP_READ) && (in_addr[11:10] == 2'b11));
        case (in_op)
            OP_WRITE: new_val = in_wdata;
            OP_SET:   new_val = old_val | in_wdata;
            OP_CLEAR: new_val = old_val & ~in_wdata;
            default:  new_val = old_val;
        endcase
        accept = in_valid && in_ready && !squash_valid;
        enq    = accept && !exc && (in_op != OP_READ);
        pop    = retire_valid && (count_q != '0) && (qid_q[head_q] == retire_id);
    end

    // Squash still lets a same-cycle retire commit, then empties the queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) head_d = ptr_inc(head_q);
            if (enq) tail_d = ptr_inc(tail_q);
            case ({enq, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        out_valid_d = accept;
        out_id_d    = out_id_q;
        out_prd_d   = out_prd_q;
        out_rdval_d = out_rdval_q;
        out_exc_d   = out_exc_q;
        if (accept) begin
            out_id_d    = in_id;
            out_prd_d   = in_prd;
            out_rdval_d = exc ? '0 : old_val;
            out_exc_d   = exc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_prd_q   <= '0;
            out_rdval_q <= '0;
            out_exc_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_prd_q   <= out_prd_d;
            out_rdval_q <= out_rdval_d;
            out_exc_q   <= out_exc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            qid_q[tail_q]   <= in_id;
            qaddr_q[tail_q] <= in_addr;
            qdata_q[tail_q] <= new_val;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_prd    = out_prd_q;
    assign out_rdval  = out_rdval_q;
    assign out_exc    = out_exc_q;
    assign csr_waddr  = qaddr_q[head_q];
    assign csr_wdata  = qdata_q[head_q];
    assign csr_wvalid = pop;

endmodule
